// File: rtl/lcd_msg_pkg.sv
// rtl/lcd_msg_pkg.sv - message codes, code validity check and scheduler state type
package lcd_msg_pkg;

  localparam int MSG_W = 4;

  localparam logic [MSG_W-1:0] MSG_BIENVENIDA    = 4'd0;
  localparam logic [MSG_W-1:0] MSG_SELECCIONE    = 4'd1;
  localparam logic [MSG_W-1:0] MSG_PRODUCTO      = 4'd3;
  localparam logic [MSG_W-1:0] MSG_PRECIO        = 4'd4;
  localparam logic [MSG_W-1:0] MSG_INSERTE       = 4'd5;
  localparam logic [MSG_W-1:0] MSG_PAGO_OK       = 4'd6;
  localparam logic [MSG_W-1:0] MSG_CAMBIO        = 4'd7;
  localparam logic [MSG_W-1:0] MSG_DISPENSANDO   = 4'd8;
  localparam logic [MSG_W-1:0] MSG_RETIRE        = 4'd9;
  localparam logic [MSG_W-1:0] MSG_AGOTADO       = 4'd10;
  localparam logic [MSG_W-1:0] MSG_ERROR_PAGO    = 4'd11;
  localparam logic [MSG_W-1:0] MSG_CANCELADO     = 4'd12;
  localparam logic [MSG_W-1:0] MSG_GRACIAS       = 4'd13;
  localparam logic [MSG_W-1:0] MSG_CONTINUAR_AST = 4'd14;

  // Codes 2 and 15 have no entry in the LCD message table.
  function automatic logic msg_valid(input logic [MSG_W-1:0] code);
    return (code != 4'd2) && (code != 4'd15);
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_SHOW = 2'd2
  } state_t;

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - free-running prescaler producing a 1-cycle pulse every millisecond
module ms_tick_gen #(
  parameter int CYC_PER_MS = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic ms_tick
);

  localparam int CW = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;

  logic [CW-1:0] cnt;

  assign ms_tick = (cnt == CW'(CYC_PER_MS - 1));

  // Count 0..CYC_PER_MS-1 and wrap; the pulse marks the wrap cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)       cnt <= '0;
    else if (ms_tick) cnt <= '0;
    else              cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/lcd_msg_scheduler.sv
// rtl/lcd_msg_scheduler.sv - fixed-priority message arbiter with minimum hold and idle timeout
module lcd_msg_scheduler
  import lcd_msg_pkg::*;
#(
  parameter int               NUM_REQ    = 4,
  parameter int               CYC_PER_MS = 50000,
  parameter int               HOLD_MS    = 500,
  parameter int               TIMEOUT_MS = 10000,
  parameter logic [MSG_W-1:0] IDLE_MSG   = MSG_BIENVENIDA
) (
  input  logic                     iCLK,
  input  logic                     iRST_N,
  input  logic [NUM_REQ-1:0]       iREQ_VALID,
  input  logic [MSG_W*NUM_REQ-1:0] iREQ_MSG,
  output logic [NUM_REQ-1:0]       oREQ_ACK,
  output logic [NUM_REQ-1:0]       oREQ_ERR,
  output logic [MSG_W-1:0]         oMSG,
  output logic                     oMSG_CHG,
  output logic                     oBUSY
);

  localparam int TO_LOAD = TIMEOUT_MS - HOLD_MS;
  localparam int HOLD_W  = $clog2(HOLD_MS) + 1;
  localparam int TO_W    = $clog2(TO_LOAD) + 1;
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t                          state, state_n;
  logic [MSG_W-1:0]                msg_n;
  logic                            chg_n;
  logic [NUM_REQ-1:0]              pend, pend_n;
  logic [NUM_REQ-1:0][MSG_W-1:0]   code_q, code_n;
  logic [HOLD_W-1:0]               hold_cnt, hold_n;
  logic [TO_W-1:0]                 to_cnt, to_n;
  logic [NUM_REQ-1:0]              req_ok, req_bad;
  logic                            grant;
  logic [IDX_W-1:0]                gnt_idx;
  logic [MSG_W-1:0]                gnt_code;
  logic                            ms_tick;

  ms_tick_gen #(.CYC_PER_MS(CYC_PER_MS)) u_tick (
    .clk     (iCLK),
    .rst_n   (iRST_N),
    .ms_tick (ms_tick)
  );

  assign oBUSY = (state == S_HOLD) || (|pend);

  // Classify this cycle's strobes into accepted and rejected codes.
  always_comb begin
    req_ok  = '0;
    req_bad = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ok[k]  = iREQ_VALID[k] &&  msg_valid(iREQ_MSG[MSG_W*k +: MSG_W]);
      req_bad[k] = iREQ_VALID[k] && !msg_valid(iREQ_MSG[MSG_W*k +: MSG_W]);
    end
  end

  // Lowest index wins; a pending slot shows its stored code, an empty slot lets a fresh request through.
  always_comb begin
    grant    = 1'b0;
    gnt_idx  = '0;
    gnt_code = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (pend[k] || req_ok[k]) begin
        grant    = 1'b1;
        gnt_idx  = IDX_W'(k);
        gnt_code = pend[k] ? code_q[k] : iREQ_MSG[MSG_W*k +: MSG_W];
      end
    end
    if (state == S_HOLD) grant = 1'b0;
  end

  // Next state, slot updates and display decisions.
  always_comb begin
    state_n = state;
    msg_n   = oMSG;
    chg_n   = 1'b0;
    pend_n  = pend;
    code_n  = code_q;
    hold_n  = hold_cnt;
    to_n    = to_cnt;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_ok[k]) begin
        pend_n[k] = 1'b1;
        code_n[k] = iREQ_MSG[MSG_W*k +: MSG_W];
      end
    end
    case (state)
      S_IDLE, S_SHOW: begin
        if (grant) begin
          msg_n   = gnt_code;
          chg_n   = 1'b1;
          hold_n  = HOLD_W'(HOLD_MS);
          state_n = S_HOLD;
          // A new request on a pending granted port refills the slot; otherwise the slot empties.
          if (!(pend[gnt_idx] && req_ok[gnt_idx])) pend_n[gnt_idx] = 1'b0;
        end else if (state == S_SHOW) begin
          if (to_cnt == '0) begin
            if (oMSG != IDLE_MSG) begin
              msg_n = IDLE_MSG;
              chg_n = 1'b1;
            end
            state_n = S_IDLE;
          end else if (ms_tick) begin
            to_n = to_cnt - TO_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (hold_cnt == '0) begin
          state_n = S_SHOW;
          to_n    = TO_W'(TO_LOAD);
        end else if (ms_tick) begin
          hold_n = hold_cnt - HOLD_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and output registers; reset drops every pending slot.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state    <= S_IDLE;
      oMSG     <= IDLE_MSG;
      oMSG_CHG <= 1'b0;
      oREQ_ACK <= '0;
      oREQ_ERR <= '0;
      pend     <= '0;
      code_q   <= '0;
      hold_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      state    <= state_n;
      oMSG     <= msg_n;
      oMSG_CHG <= chg_n;
      oREQ_ACK <= req_ok;
      oREQ_ERR <= req_bad;
      pend     <= pend_n;
      code_q   <= code_n;
      hold_cnt <= hold_n;
      to_cnt   <= to_n;
    end
  end

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// tb/tb_lcd_msg_scheduler.sv - self-checking bench for lcd_msg_scheduler
module tb_lcd_msg_scheduler;

  localparam int NREQ = 4;
  localparam int CYC  = 4;
  localparam int HOLD = 3;
  localparam int TOUT = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [15:0] req_msg;
  logic [3:0]  ack, err;
  logic [3:0]  msg;
  logic        chg, busy;

  always #5 clk = ~clk;

  lcd_msg_scheduler #(
    .NUM_REQ(NREQ), .CYC_PER_MS(CYC), .HOLD_MS(HOLD), .TIMEOUT_MS(TOUT), .IDLE_MSG(4'd0)
  ) dut (
    .iCLK(clk), .iRST_N(rstn), .iREQ_VALID(req_valid), .iREQ_MSG(req_msg),
    .oREQ_ACK(ack), .oREQ_ERR(err), .oMSG(msg), .oMSG_CHG(chg), .oBUSY(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 0;
  int busy_seen = 0;
  logic [3:0] chg_msg[$];
  int         chg_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference model: ms elapsed in hold/show counted upward, slots as plain arrays.
  int         presc;
  bit         m_hold, m_show;
  int         m_hms, m_sms;
  logic [3:0] m_msg, m_ack, m_err;
  logic       m_chg, m_busy;
  bit         m_pend[NREQ];
  logic [3:0] m_code[NREQ];

  always @(posedge clk) begin : model
    bit         tick;
    int         win;
    bit         ok[NREQ];
    logic [3:0] rc[NREQ];
    cyc++;
    if (!rstn) begin
      presc = 0; m_hold = 0; m_show = 0; m_hms = 0; m_sms = 0;
      m_msg = 0; m_ack = 0; m_err = 0; m_chg = 0;
      for (int k = 0; k < NREQ; k++) begin m_pend[k] = 0; m_code[k] = 0; end
    end else begin
      tick  = (presc == CYC - 1);
      presc = tick ? 0 : presc + 1;
      m_chg = 0;
      for (int k = 0; k < NREQ; k++) begin
        rc[k]    = req_msg[4*k +: 4];
        ok[k]    = req_valid[k] && rc[k] != 4'd2 && rc[k] != 4'd15;
        m_ack[k] = ok[k];
        m_err[k] = req_valid[k] && !ok[k];
      end
      win = -1;
      if (!m_hold)
        for (int k = NREQ - 1; k >= 0; k--) if (m_pend[k] || ok[k]) win = k;
      if (m_hold) begin
        if (m_hms == HOLD) begin m_hold = 0; m_show = 1; m_sms = 0; end
        else if (tick) m_hms++;
      end else if (win >= 0) begin
        m_msg  = m_pend[win] ? m_code[win] : rc[win];
        m_chg  = 1;
        m_hold = 1; m_show = 0; m_hms = 0;
        if (m_pend[win] && ok[win]) m_code[win] = rc[win];
        else m_pend[win] = 0;
        ok[win] = 0;
      end else if (m_show) begin
        if (m_sms == TOUT - HOLD) begin
          m_show = 0;
          if (m_msg != 4'd0) begin m_msg = 4'd0; m_chg = 1; end
        end else if (tick) m_sms++;
      end
      for (int k = 0; k < NREQ; k++) if (ok[k]) begin m_pend[k] = 1; m_code[k] = rc[k]; end
    end
    m_busy = m_hold;
    for (int k = 0; k < NREQ; k++) if (m_pend[k]) m_busy = 1;
  end

  // Per-cycle comparison against the model, plus a log of every displayed change.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("msg", msg, m_msg);
      chk("msg_chg", chg, m_chg);
      chk("ack", ack, m_ack);
      chk("err", err, m_err);
      chk("busy", busy, m_busy);
      if (chg) begin chg_msg.push_back(msg); chg_cyc.push_back(cyc); end
      if (busy) busy_seen++;
    end
  end

  task automatic drive(input logic [3:0] v, input logic [15:0] m);
    @(posedge clk); #2;
    req_valid = v;
    req_msg   = m;
  endtask

  task automatic pulse(input logic [3:0] v, input logic [15:0] m);
    drive(v, m);
    drive(4'd0, 16'd0);
    @(negedge clk); #1;
  endtask

  task automatic wait_chg(input string name, input int bound, output logic [3:0] m, output int at);
    int start = chg_msg.size();
    bit ok = 0;
    m = 4'hx; at = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk); #1;
      if (chg_msg.size() > start) ok = 1;
    end
    chk({name, "_seen"}, ok, 1);
    if (ok) begin m = chg_msg[start]; at = chg_cyc[start]; end
  endtask

  function automatic int count_code(input logic [3:0] c, input int from);
    int n = 0;
    for (int i = from; i < chg_msg.size(); i++) if (chg_msg[i] == c) n++;
    return n;
  endfunction

  initial begin : stim
    logic [3:0] m;
    int at, t0, s;
    rstn = 0; req_valid = 0; req_msg = 0;
    repeat (3) @(posedge clk);
    #2 rstn = 1; cmp_en = 1;
    @(negedge clk); #1;
    chk("rst_msg", msg, 0); chk("rst_busy", busy, 0); chk("rst_ack", ack, 0);

    // 1: quiet display for 200 cycles
    s = chg_msg.size(); busy_seen = 0;
    repeat (200) @(negedge clk);
    #1;
    chk("t1_chg_count", chg_msg.size() - s, 0);
    chk("t1_busy", busy_seen, 0);
    chk("t1_msg", msg, 0);

    // 2: single request goes straight to the display, then times out to idle
    pulse(4'b0010, 16'h0050);
    chk("t2_ack", ack, 4'b0010); chk("t2_msg", msg, 5); chk("t2_chg", chg, 1);
    t0 = cyc;
    wait_chg("t2_timeout", 60, m, at);
    chk("t2_idle_msg", m, 0);
    // 8 ms of ticks, first ms possibly partial, plus two state-transition cycles
    chk_range("t2_show_cycles", at - t0, 30, 36);

    // 3: simultaneous requests, lowest port first, the other after one hold
    s = chg_msg.size();
    pulse(4'b1001, 16'hC009);
    chk("t3_ack", ack, 4'b1001); chk("t3_msg", msg, 9); chk("t3_busy", busy, 1);
    t0 = cyc;
    wait_chg("t3_second", 40, m, at);
    chk("t3_second_msg", m, 12);
    chk_range("t3_hold_cycles", at - t0, 11, 16);
    wait_chg("t3_timeout", 80, m, at);
    chk("t3_idle_msg", m, 0);
    chk("t3_count12", count_code(4'd12, s), 1);

    // 4: overwrite during hold, only the latest code is shown
    s = chg_msg.size();
    pulse(4'b0010, 16'h0050);
    chk("t4_first", msg, 5);
    pulse(4'b0100, 16'h0600);
    chk("t4_ack6", ack, 4'b0100); chk("t4_msg_held", msg, 5);
    pulse(4'b0100, 16'h0700);
    chk("t4_ack7", ack, 4'b0100);
    wait_chg("t4_next", 40, m, at);
    chk("t4_next_msg", m, 7);
    wait_chg("t4_timeout", 80, m, at);
    chk("t4_count6", count_code(4'd6, s), 0);

    // 5: undefined codes are rejected without touching the display
    s = chg_msg.size();
    pulse(4'b0001, 16'h0002);
    chk("t5_err2", err, 4'b0001); chk("t5_noack2", ack, 0); chk("t5_nochg2", chg, 0);
    pulse(4'b0001, 16'h000F);
    chk("t5_err15", err, 4'b0001); chk("t5_noack15", ack, 0);
    repeat (10) @(negedge clk);
    #1;
    chk("t5_chg_count", chg_msg.size() - s, 0);
    chk("t5_msg", msg, 0); chk("t5_busy", busy, 0);

    // 6: reset in mid-hold drops the pending request
    drive(4'b0010, 16'h0050);
    drive(4'b0010, 16'h0080);
    drive(4'd0, 16'd0);
    @(negedge clk); #1;
    chk("t6_msg_before", msg, 5); chk("t6_busy_before", busy, 1);
    @(posedge clk); #2 rstn = 0;
    @(posedge clk); #2 rstn = 1;
    @(negedge clk); #1;
    chk("t6_msg", msg, 0); chk("t6_chg", chg, 0); chk("t6_ack", ack, 0);
    chk("t6_err", err, 0); chk("t6_busy", busy, 0);
    s = chg_msg.size();
    repeat (80) @(negedge clk);
    #1;
    chk("t6_count8", count_code(4'd8, s), 0);
    chk("t6_chg_count", chg_msg.size() - s, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
